// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: FSM encoding and read-latency limits.
package dmem_pkg;

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Out-of-range latencies are clamped into the supported 1..2 window.
  function automatic int legal_rd_lat(input int lat);
    return (lat >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with registered read (read-before-write).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: request/response handshake, one- or two-word beats,
// post-reset clear sweep and a configurable read-latency output pipe.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_wide,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                busy
);

  localparam int         LAT      = legal_rd_lat(RD_LAT);
  localparam logic [1:0] ST_RESET = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [1:0]          state_reg, state_next;
  logic [ADDR_W-1:0]   clr_addr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wdata_lo_reg;
  logic [DATA_W-1:0]   hi_reg;
  logic                ram_vld_reg;
  logic                ram_wide_reg;

  logic                accept;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic [2*DATA_W-1:0] beat_data;
  logic [LAT:0]        vld_chain;

  assign accept = req_valid && (state_reg == ST_IDLE);

  // Beat address/data mux: clear sweep, first beat straight from the request, second beat from captured state.
  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_addr   = req_addr;
    ram_wdata  = req_wide ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    case (state_reg)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr_reg;
        ram_wdata = '0;
        if (&clr_addr_reg) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ram_we = accept && req_we;
        if (accept && req_wide) begin
          state_next = ST_SECOND;
        end
      end
      ST_SECOND: begin
        ram_we     = we_reg;
        ram_addr   = addr_reg + ADDR_W'(1);
        ram_wdata  = wdata_lo_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_RESET;
    endcase
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RESET;
      clr_addr_reg <= '0;
      ram_vld_reg  <= 1'b0;
      ram_wide_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_CLEAR) begin
        clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
      end
      ram_vld_reg  <= (accept && !req_we && !req_wide) ||
                      ((state_reg == ST_SECOND) && !we_reg);
      ram_wide_reg <= (state_reg == ST_SECOND);
    end
  end

  // Request capture and the high word of a wide read need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg       <= req_we;
      addr_reg     <= req_addr;
      wdata_lo_reg <= req_wdata[DATA_W-1:0];
    end
    if (state_reg == ST_SECOND) begin
      hi_reg <= ram_rdata;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign beat_data    = ram_wide_reg ? {hi_reg, ram_rdata} : {{DATA_W{1'b0}}, ram_rdata};
  assign vld_chain[0] = ram_vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      logic                vld_q;
      logic [2*DATA_W-1:0] data_q;
      logic                vld_in;
      logic [2*DATA_W-1:0] data_in;

      if (gi == 0) begin : g_first
        assign vld_in  = ram_vld_reg;
        assign data_in = beat_data;
      end else begin : g_next
        assign vld_in  = g_stage[gi-1].vld_q;
        assign data_in = g_stage[gi-1].data_q;
      end

      // Data only advances with a valid beat so the last stage holds between responses.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          data_q <= '0;
        end else begin
          vld_q <= vld_in;
          if (vld_in) begin
            data_q <= data_in;
          end
        end
      end

      assign vld_chain[gi+1] = vld_q;
    end
  endgenerate

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = vld_chain[LAT];
  assign rsp_data  = g_stage[LAT-1].data_q;
  assign busy      = (state_reg != ST_IDLE) || (|vld_chain[LAT-1:0]);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: instance a (RD_LAT=1, clear on reset) and b (RD_LAT=2, no clear), DEPTH=16.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_wide = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        valid_a, valid_b;
  logic        ready_a, ready_b, rv_a, rv_b, busy_a, busy_b;
  logic [31:0] rd_a, rd_b;
  logic        ready, rsp_valid, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;

  assign valid_a   = req_valid & ~sel;
  assign valid_b   = req_valid & sel;
  assign ready     = sel ? ready_b : ready_a;
  assign rsp_valid = sel ? rv_b : rv_a;
  assign rsp_data  = sel ? rd_b : rd_a;
  assign busy      = sel ? busy_b : busy_a;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_data(rd_a), .busy(busy_a)
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLR_ON_RST(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_data(rd_b), .busy(busy_b)
  );

  // Present one request, wait (bounded) for ready, return 1 ns after the accepting edge.
  task automatic issue(input logic we, input logic wide, input logic [3:0] addr, input logic [31:0] wdata);
    int n;
    req_we = we; req_wide = wide; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL issue_ready_timeout got=%0b exp=1", ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Issue a read and report how many edges after acceptance rsp_valid appeared (-1 if never).
  task automatic read_obs(input logic wide, input logic [3:0] addr, output int edges, output logic [31:0] data);
    issue(1'b0, wide, addr, 32'h0);
    edges = -1;
    data  = 32'hxxxx_xxxx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        edges = k;
        data  = rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n, e, exp_clr;
    logic [31:0] d;
    exp_clr = sel ? 0 : 16;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ready !== (exp_clr == 0)) begin failures++; $display("FAIL reset_ready got=%0b exp=%0b", ready, exp_clr == 0); end
    checks++;
    if (busy !== (exp_clr != 0)) begin failures++; $display("FAIL reset_busy got=%0b exp=%0b", busy, exp_clr != 0); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++;
    if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00000000", rsp_data); end
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== exp_clr) begin failures++; $display("FAIL clear_cycles got=%0d exp=%0d", n, exp_clr); end
    if (!sel) begin
      for (int a = 0; a < 16; a++) begin
        read_obs(1'b0, 4'(a), e, d);
        checks++;
        if (e !== 1 || d !== 32'h0) begin
          failures++;
          $display("FAIL cleared_word addr=%0d got=%h lat=%0d exp=00000000 lat=1", a, d, e);
        end
      end
    end
  endtask

  task automatic test_narrow();
    int e, lat;
    logic [31:0] d;
    lat = sel ? 2 : 1;
    issue(1'b1, 1'b0, 4'd5, 32'h5A5A_BEEF);
    read_obs(1'b0, 4'd5, e, d);
    checks++;
    if (e !== lat) begin failures++; $display("FAIL narrow_lat got=%0d exp=%0d", e, lat); end
    checks++;
    if (d !== 32'h0000_BEEF) begin failures++; $display("FAIL narrow_data got=%h exp=0000beef", d); end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL narrow_pulse got=%0b exp=0", rsp_valid); end
    checks++;
    if (rsp_data !== 32'h0000_BEEF) begin failures++; $display("FAIL narrow_hold got=%h exp=0000beef", rsp_data); end
    issue(1'b1, 1'b0, 4'd6, 32'h0000_CAFE);
    read_obs(1'b0, 4'd6, e, d);
    checks++;
    if (d !== 32'h0000_CAFE || e !== lat) begin failures++; $display("FAIL narrow_addr6 got=%h lat=%0d exp=0000cafe lat=%0d", d, e, lat); end
    read_obs(1'b0, 4'd5, e, d);
    checks++;
    if (d !== 32'h0000_BEEF) begin failures++; $display("FAIL narrow_addr5_again got=%h exp=0000beef", d); end
  endtask

  task automatic test_wide();
    int e, lat;
    logic [31:0] d;
    lat = sel ? 2 : 1;
    issue(1'b1, 1'b1, 4'd15, 32'h1234_5678);
    read_obs(1'b0, 4'd15, e, d);
    checks++;
    if (d !== 32'h0000_1234) begin failures++; $display("FAIL wide_hi_word got=%h exp=00001234", d); end
    read_obs(1'b0, 4'd0, e, d);
    checks++;
    if (d !== 32'h0000_5678) begin failures++; $display("FAIL wide_wrap_word got=%h exp=00005678", d); end
    read_obs(1'b1, 4'd15, e, d);
    checks++;
    if (e !== lat + 1) begin failures++; $display("FAIL wide_lat got=%0d exp=%0d", e, lat + 1); end
    checks++;
    if (d !== 32'h1234_5678) begin failures++; $display("FAIL wide_data got=%h exp=12345678", d); end
    read_obs(1'b1, 4'd5, e, d);
    checks++;
    if (d !== 32'hBEEF_CAFE) begin failures++; $display("FAIL wide_read5 got=%h exp=beefcafe", d); end
  endtask

  task automatic test_back_to_back();
    int n, lat;
    logic [31:0] got [4];
    int pos [4];
    logic [31:0] exp_w [2];
    lat = sel ? 2 : 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b0;
      req_addr = 4'(8 + i); req_wdata = 32'h1000 + 32'(i);
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready beat=%0d got=%0b exp=1", i, ready); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_addr = 4'(8 + i);
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL b2b_rd_ready beat=%0d got=%0b exp=1", i, ready); end
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (rsp_valid) begin
        if (n < 4) begin got[n] = rsp_data; pos[n] = i; end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      checks++;
      if (got[k] !== 32'h1000 + 32'(k) || pos[k] !== k + lat) begin
        failures++;
        $display("FAIL b2b_rd_rsp idx=%0d got=%h at=%0d exp=%h at=%0d", k, got[k], pos[k], 32'h1000 + 32'(k), k + lat);
      end
    end
    exp_w[0] = 32'h1000_1001;
    exp_w[1] = 32'h1002_1003;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b1;
        req_addr = (i < 2) ? 4'd8 : 4'd10;
        checks++;
        if (ready !== (i % 2 == 0)) begin failures++; $display("FAIL wide_ready cyc=%0d got=%0b exp=%0b", i, ready, i % 2 == 0); end
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (rsp_valid) begin
        if (n < 2) begin got[n] = rsp_data; pos[n] = i; end
        n++;
      end
    end
    checks++;
    if (n !== 2) begin failures++; $display("FAIL wide_b2b_count got=%0d exp=2", n); end
    for (int k = 0; k < 2 && k < n; k++) begin
      checks++;
      if (got[k] !== exp_w[k] || pos[k] !== 2 * k + 1 + lat) begin
        failures++;
        $display("FAIL wide_b2b_rsp idx=%0d got=%h at=%0d exp=%h at=%0d", k, got[k], pos[k], exp_w[k], 2 * k + 1 + lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, pulses, e;
    logic [31:0] d;
    issue(1'b0, 1'b1, 4'd15, 32'h0);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL mid_second busy=%0b ready=%0b exp busy=1 ready=0", busy, ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_reset_busy got=%0b exp=1", busy); end
    pulses = 0;
    n = 0;
    while (!ready && n < 40) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid) pulses++;
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL mid_dropped_rsp got=%0d exp=0", pulses); end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL mid_clear_cycles got=%0d exp=16", n); end
    for (int a = 0; a < 16; a++) begin
      read_obs(1'b0, 4'(a), e, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL mid_swept_word addr=%0d got=%h exp=00000000", a, d); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    sel = 1'b0;
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    sel = 1'b1;
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
